// File: rtl/logic_gate_unit.sv
`default_nettype none
// ============================================================================
// Module      : logic_gate_unit
// Description : Registered bitwise gate unit. Applies one of eight two-operand
//               logic functions to WIDTH-bit operands and presents the result
//               through a one-entry valid/ready output register. Counts
//               completed output transfers (wrapping).
//               Optional macro LOGIC_GATE_UNIT_REDUCE_EN adds registered
//               AND/OR/XOR reduction flags of the result; when it is
//               undefined the flags are tied to 0.
// Revision    : 1.0 - initial release
// ============================================================================
module logic_gate_unit #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             red_and,
    output logic             red_or,
    output logic             red_xor,
    output logic [CNT_W-1:0] xfer_cnt
);

    // Function select encoding
    localparam logic [2:0] C_OP_AND  = 3'd0;
    localparam logic [2:0] C_OP_OR   = 3'd1;
    localparam logic [2:0] C_OP_XOR  = 3'd2;
    localparam logic [2:0] C_OP_NAND = 3'd3;
    localparam logic [2:0] C_OP_NOR  = 3'd4;
    localparam logic [2:0] C_OP_XNOR = 3'd5;
    localparam logic [2:0] C_OP_NOTA = 3'd6;
    localparam logic [2:0] C_OP_PASS = 3'd7;

    // The state bit is the output-valid flag itself
    typedef enum logic [0:0] {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_y;
    logic [CNT_W-1:0]   r_xfer_cnt;
    logic [WIDTH-1:0]   w_result;
    logic               w_in_xfer;
    logic               w_out_xfer;

    assign out_valid  = (r_state == S_FULL);
    // The register can take a new result whenever it is empty or being drained
    assign in_ready   = !out_valid || out_ready;
    assign w_in_xfer  = in_valid && in_ready;
    assign w_out_xfer = out_valid && out_ready;
    assign y          = r_y;
    assign xfer_cnt   = r_xfer_cnt;

    // Select the logic function applied to the operands
    always_comb begin
        w_result = '0;
        case (op)
            C_OP_AND:  w_result = a & b;
            C_OP_OR:   w_result = a | b;
            C_OP_XOR:  w_result = a ^ b;
            C_OP_NAND: w_result = ~(a & b);
            C_OP_NOR:  w_result = ~(a | b);
            C_OP_XNOR: w_result = ~(a ^ b);
            C_OP_NOTA: w_result = ~a;
            C_OP_PASS: w_result = a;
            default:   w_result = '0;
        endcase
    end

    // Output register, occupancy state and transfer counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_EMPTY;
            r_y        <= '0;
            r_xfer_cnt <= '0;
        end else begin
            if (w_in_xfer) begin
                r_y <= w_result;
            end
            if (w_out_xfer) begin
                r_xfer_cnt <= r_xfer_cnt + CNT_W'(1);
            end
            case (r_state)
                S_EMPTY: begin
                    if (w_in_xfer) begin
                        r_state <= S_FULL;
                    end
                end
                S_FULL: begin
                    // A simultaneous refill keeps the register full with no bubble
                    if (w_out_xfer && !w_in_xfer) begin
                        r_state <= S_EMPTY;
                    end
                end
                default: r_state <= S_EMPTY;
            endcase
        end
    end

`ifdef LOGIC_GATE_UNIT_REDUCE_EN
    logic r_red_and;
    logic r_red_or;
    logic r_red_xor;

    // Reductions of the new result, loaded on the same edge as the result
    always_ff @(posedge clk) begin
        if (rst) begin
            r_red_and <= 1'b0;
            r_red_or  <= 1'b0;
            r_red_xor <= 1'b0;
        end else if (w_in_xfer) begin
            r_red_and <= &w_result;
            r_red_or  <= |w_result;
            r_red_xor <= ^w_result;
        end
    end

    assign red_and = r_red_and;
    assign red_or  = r_red_or;
    assign red_xor = r_red_xor;
`else
    assign red_and = 1'b0;
    assign red_or  = 1'b0;
    assign red_xor = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_logic_gate_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_logic_gate_unit
// Description : Self-checking bench for logic_gate_unit (WIDTH=8). A second
//               instance with CNT_W=2 shares all inputs to observe counter wrap.
//               Expected results are queued when operands are accepted and
//               compared while the unit holds them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_logic_gate_unit;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       op;
    logic             in_valid;
    logic             out_ready;

    logic             in_ready;
    logic [WIDTH-1:0] y;
    logic             out_valid;
    logic             red_and;
    logic             red_or;
    logic             red_xor;
    logic [15:0]      xfer_cnt;

    logic             in_ready2;
    logic [WIDTH-1:0] y2;
    logic             out_valid2;
    logic             red_and2;
    logic             red_or2;
    logic             red_xor2;
    logic [1:0]       xfer_cnt2;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state
    logic [WIDTH-1:0] exp_q[$];
    logic             m_valid;
    logic [WIDTH-1:0] m_y;
    logic [15:0]      m_cnt;
    logic [1:0]       m_cnt2;

    logic_gate_unit #(.WIDTH(WIDTH), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .a(a), .b(b), .op(op),
        .in_valid(in_valid), .in_ready(in_ready),
        .y(y), .out_valid(out_valid), .out_ready(out_ready),
        .red_and(red_and), .red_or(red_or), .red_xor(red_xor),
        .xfer_cnt(xfer_cnt)
    );

    logic_gate_unit #(.WIDTH(WIDTH), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .a(a), .b(b), .op(op),
        .in_valid(in_valid), .in_ready(in_ready2),
        .y(y2), .out_valid(out_valid2), .out_ready(out_ready),
        .red_and(red_and2), .red_or(red_or2), .red_xor(red_xor2),
        .xfer_cnt(xfer_cnt2)
    );

    always #5 clk = ~clk;

    function automatic logic [WIDTH-1:0] model_op(input logic [2:0] f,
                                                  input logic [WIDTH-1:0] x,
                                                  input logic [WIDTH-1:0] z);
        case (f)
            3'd0:    return x & z;
            3'd1:    return x | z;
            3'd2:    return x ^ z;
            3'd3:    return ~(x & z);
            3'd4:    return ~(x | z);
            3'd5:    return ~(x ^ z);
            3'd6:    return ~x;
            default: return x;
        endcase
    endfunction

    // Advance one clock: update the model at the rising edge, return at the falling edge
    task automatic tick();
        logic ix;
        logic ox;
        @(posedge clk);
        if (rst) begin
            exp_q.delete();
            m_valid = 1'b0;
            m_y     = '0;
            m_cnt   = '0;
            m_cnt2  = '0;
        end else begin
            ox = m_valid && out_ready;
            ix = in_valid && (!m_valid || out_ready);
            if (ox) begin
                void'(exp_q.pop_front());
                m_cnt  = m_cnt + 16'd1;
                m_cnt2 = m_cnt2 + 2'd1;
            end
            if (ix) begin
                m_y = model_op(op, a, b);
                exp_q.push_back(m_y);
            end
            m_valid = ix || (m_valid && !ox);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
        a = 8'hFF; b = 8'hFF; op = 3'd0;
        tick(); tick();
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end vectors++;
        if (y !== 8'h00) begin miscompares++; $display("FAIL reset_y: got %h want 00", y); end vectors++;
        if (xfer_cnt !== 16'd0) begin miscompares++; $display("FAIL reset_xfer_cnt: got %0d want 0", xfer_cnt); end vectors++;
        if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end vectors++;
        if ({red_and, red_or, red_xor} !== 3'b000) begin miscompares++; $display("FAIL reset_red: got %b want 000", {red_and, red_or, red_xor}); end vectors++;
        rst = 1'b0; in_valid = 1'b0;
    endtask

    task automatic test_truth_table();
        logic [WIDTH-1:0] tbl [8];
        tbl = '{8'hC0, 8'hFC, 8'h3C, 8'h3F, 8'h03, 8'hC3, 8'h0F, 8'hF0};
        out_ready = 1'b1; a = 8'hF0; b = 8'hCC;
        for (int i = 0; i < 8; i++) begin
            op = 3'(i); in_valid = 1'b1;
            tick();
            if (out_valid !== 1'b1) begin miscompares++; $display("FAIL tt_valid op%0d: got %b want 1", i, out_valid); end vectors++;
            if (y !== tbl[i]) begin miscompares++; $display("FAIL tt_y op%0d: got %h want %h", i, y, tbl[i]); end vectors++;
            if (exp_q.size() > 0) begin
                if (y !== exp_q[0]) begin miscompares++; $display("FAIL tt_scoreboard op%0d: got %h want %h", i, y, exp_q[0]); end vectors++;
            end
        end
        in_valid = 1'b0;
        tick();
        if (xfer_cnt !== 16'd8) begin miscompares++; $display("FAIL tt_xfer_cnt: got %0d want 8", xfer_cnt); end vectors++;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL tt_drained: got %b want 0", out_valid); end vectors++;
    endtask

    task automatic test_back_pressure();
        logic [15:0] base;
        base = m_cnt;
        out_ready = 1'b0; in_valid = 1'b1; a = 8'hFF; b = 8'hAA; op = 3'd0;
        tick();
        if (y !== 8'hAA) begin miscompares++; $display("FAIL bp_load: got %h want aa", y); end vectors++;
        for (int i = 0; i < 3; i++) begin
            a = 8'($urandom); b = 8'($urandom); op = 3'($urandom); in_valid = 1'b1;
            #1;
            if (in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_in_ready c%0d: got %b want 0", i, in_ready); end vectors++;
            tick();
            if (y !== 8'hAA || out_valid !== 1'b1) begin miscompares++; $display("FAIL bp_hold c%0d: got y=%h v=%b want y=aa v=1", i, y, out_valid); end vectors++;
            if (xfer_cnt !== base) begin miscompares++; $display("FAIL bp_cnt c%0d: got %0d want %0d", i, xfer_cnt, base); end vectors++;
        end
        out_ready = 1'b1; a = 8'h0F; b = 8'hF0; op = 3'd1; in_valid = 1'b1;
        tick();
        if (y !== 8'hFF || y !== exp_q[0]) begin miscompares++; $display("FAIL bp_next: got %h want ff", y); end vectors++;
        if (xfer_cnt !== base + 16'd1) begin miscompares++; $display("FAIL bp_cnt_release: got %0d want %0d", xfer_cnt, base + 16'd1); end vectors++;
        in_valid = 1'b0;
        tick();
        if (out_valid !== 1'b0 || xfer_cnt !== base + 16'd2) begin miscompares++; $display("FAIL bp_drain: got v=%b cnt=%0d want v=0 cnt=%0d", out_valid, xfer_cnt, base + 16'd2); end vectors++;
    endtask

    task automatic test_back_to_back();
        logic [15:0] base;
        out_ready = 1'b0; in_valid = 1'b1; a = 8'h55; b = 8'h00; op = 3'd7;
        tick();
        base = m_cnt;
        out_ready = 1'b1; in_valid = 1'b1; a = 8'h01; b = 8'h02; op = 3'd1;
        #1;
        if (in_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_in_ready: got %b want 1", in_ready); end vectors++;
        tick();
        if (y !== 8'h03 || out_valid !== 1'b1) begin miscompares++; $display("FAIL b2b_y: got y=%h v=%b want y=03 v=1", y, out_valid); end vectors++;
        if (xfer_cnt !== base + 16'd1 || xfer_cnt !== m_cnt) begin miscompares++; $display("FAIL b2b_cnt: got %0d want %0d", xfer_cnt, base + 16'd1); end vectors++;
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_reductions();
        logic [WIDTH-1:0] va [3];
        logic [WIDTH-1:0] vb [3];
        logic [2:0]       vo [3];
        logic [2:0]       exp_red;
        va = '{8'hFF, 8'h0F, 8'h01};
        vb = '{8'h00, 8'h0F, 8'h00};
        vo = '{3'd2, 3'd0, 3'd2};
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a = va[i]; b = vb[i]; op = vo[i]; in_valid = 1'b1;
            tick();
`ifdef LOGIC_GATE_UNIT_REDUCE_EN
            exp_red = {&m_y, |m_y, ^m_y};
`else
            exp_red = 3'b000;
`endif
            if ({red_and, red_or, red_xor} !== exp_red) begin miscompares++; $display("FAIL red v%0d: got %b want %b", i, {red_and, red_or, red_xor}, exp_red); end vectors++;
        end
`ifdef LOGIC_GATE_UNIT_REDUCE_EN
        in_valid = 1'b0;
        tick();
        if ({red_and, red_or, red_xor} !== 3'b011) begin miscompares++; $display("FAIL red_hold: got %b want 011", {red_and, red_or, red_xor}); end vectors++;
`else
        in_valid = 1'b0;
        tick();
`endif
    endtask

    task automatic test_cnt_wrap();
        rst = 1'b1; in_valid = 1'b0;
        tick();
        rst = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            a = 8'(i); b = 8'hFF; op = 3'd2; in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        tick();
        if (xfer_cnt2 !== 2'd1 || xfer_cnt2 !== m_cnt2) begin miscompares++; $display("FAIL wrap_cnt2: got %0d want 1", xfer_cnt2); end vectors++;
        if (xfer_cnt !== 16'd5) begin miscompares++; $display("FAIL wrap_cnt16: got %0d want 5", xfer_cnt); end vectors++;
    endtask

    task automatic test_mid_reset();
        out_ready = 1'b0; in_valid = 1'b1; a = 8'h3C; b = 8'hFF; op = 3'd0;
        tick();
        if (out_valid !== 1'b1) begin miscompares++; $display("FAIL mr_full: got %b want 1", out_valid); end vectors++;
        rst = 1'b1; out_ready = 1'b1; in_valid = 1'b1;
        tick();
        if (out_valid !== 1'b0 || y !== 8'h00) begin miscompares++; $display("FAIL mr_clear: got v=%b y=%h want v=0 y=00", out_valid, y); end vectors++;
        if (xfer_cnt !== 16'd0 || xfer_cnt2 !== 2'd0) begin miscompares++; $display("FAIL mr_cnt: got %0d/%0d want 0/0", xfer_cnt, xfer_cnt2); end vectors++;
        rst = 1'b0; in_valid = 1'b0;
        tick();
        if (xfer_cnt !== 16'd0 || out_valid !== 1'b0) begin miscompares++; $display("FAIL mr_after: got cnt=%0d v=%b want 0/0", xfer_cnt, out_valid); end vectors++;
    endtask

    initial begin
        rst = 1'b1; a = '0; b = '0; op = '0; in_valid = 1'b0; out_ready = 1'b0;
        m_valid = 1'b0; m_y = '0; m_cnt = '0; m_cnt2 = '0;
        @(negedge clk);
        test_reset();
        test_truth_table();
        test_back_pressure();
        test_back_to_back();
        test_reductions();
        test_cnt_wrap();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/logic_gate_unit.md
# logic_gate_unit

- Registered, parametrised bitwise gate unit.
- Applies one of eight two-operand logic functions to WIDTH-bit operands `a` and `b`.
- Delivers each result through a one-entry output register with a valid/ready handshake.
- Counts completed transfers.
- Generalises the single 2-input AND gate: wider operands, selectable function, back-pressure, optional reduction flags.
- Sits between operand producers and any consumer that may stall.

## Interface

Parameters:
- `WIDTH`, 8: operand and result width in bits (>= 1).
- `CNT_W`, 16: width of the transfer counter (>= 1).

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `a`  in  WIDTH  operand A.
- `b`  in  WIDTH  operand B.
- `op`  in  3  function select, sampled with the operands.
- `in_valid`  in  1  operands and `op` are valid this cycle.
- `in_ready`  out  1  unit accepts operands this cycle.
- `y`  out  WIDTH  registered result.
- `out_valid`  out  1  `y` holds an undelivered result.
- `out_ready`  in  1  consumer accepts `y` this cycle.
- `red_and`, `red_or`, `red_xor`  out  1 each  reductions of `y`; registered together with `y`.
- `xfer_cnt`  out  CNT_W  number of completed output transfers.

## Operation

- `op` encoding:
  - 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR.
  - 6 NOT a (`b` ignored).
  - 7 PASS a (`y` = `a`).
- Input transfer: `in_valid && in_ready` at a rising edge.
- Output transfer: `out_valid && out_ready` at a rising edge.
- `in_ready = !out_valid || out_ready`. This is combinational from `out_ready` and is the only combinational input-to-output path.
- On an input transfer, the edge loads `y`, `red_*`, and sets `out_valid` = 1.
- On an output transfer with no simultaneous input transfer, the edge clears `out_valid`. `y` and `red_*` hold their last values.
- Simultaneous output and input transfer in the same cycle: the new result replaces the old and `out_valid` stays 1. No bubble, no loss.
- While `out_valid && !out_ready`:
  - `y`, `red_*` and `out_valid` are stable.
  - Input is not accepted (`in_ready` = 0).
  - Inputs are don't-care.
- `xfer_cnt` increments by 1 on every output transfer. It wraps modulo 2^CNT_W with no saturation and no flag.
- State machine, two states:
  - EMPTY (`out_valid` = 0): input transfer -> FULL.
  - FULL (`out_valid` = 1):
    - output transfer without input transfer -> EMPTY.
    - otherwise stay FULL.
- Reset:
  - `out_valid` = 0, `y` = 0, `red_and` = 0, `red_or` = 0, `red_xor` = 0, `xfer_cnt` = 0.
  - Reset overrides any transfer in the same cycle.
  - A result pending at reset is discarded and not counted.

## Timing

- Latency: 1 cycle. Operands accepted at edge N appear on `y` with `out_valid` = 1 immediately after edge N.
- Throughput: 1 result per cycle when `out_ready` is held 1.
- `in_ready` after reset: 1.
- All outputs except `in_ready` are register outputs.
- The cycle `rst` is deasserted, the unit may accept input at the next edge.

## Configuration

- Macro: `LOGIC_GATE_UNIT_REDUCE_EN`.
- Defined: `red_and` = &y, `red_or` = |y, `red_xor` = ^y of the new result. These are registered on the same edge as `y`.
- Undefined: the reduction logic and registers are not compiled. `red_and`, `red_or` and `red_xor` are tied to 0. Ports remain present.

## Test plan

All scenarios use WIDTH=8.

- Reset check: `rst` = 1 for 2 cycles with `in_valid` = 1 -> `out_valid` = 0, `y` = 0, `xfer_cnt` = 0, `in_ready` = 1.
- Truth-table sweep, `out_ready` = 1, `a` = 8'hF0, `b` = 8'hCC:
  - op 0..7 back-to-back -> `y` = 8'hC0, 8'hFC, 8'h3C, 8'h3F, 8'h03, 8'hC3, 8'h0F, 8'hF0 on consecutive cycles.
  - `xfer_cnt` = 8 at the end.
- Back-pressure: accept AND of 8'hFF/8'hAA, hold `out_ready` = 0 for 3 cycles while driving new operands:
  - `y` stays 8'hAA, `in_ready` = 0, `xfer_cnt` unchanged.
  - After releasing `out_ready`, the next accepted result follows without loss.
- Simultaneous transfer: FULL with `out_ready` = 1 and `in_valid` = 1 (OR 8'h01/8'h02) -> next cycle `y` = 8'h03, `out_valid` = 1, `xfer_cnt` +1.
- Reductions, with the macro defined: XOR of 8'hFF/8'h00 -> `red_and` = 1, `red_or` = 1, `red_xor` = 0. With the macro undefined, all three read 0.
- Counter wrap and mid-operation reset:
  - CNT_W=2, 5 transfers -> `xfer_cnt` = 1.
  - Assert `rst` while FULL -> `out_valid` = 0 next cycle and the pending result is never counted.
